id_ex_pipe: RTL and testbench

//  ID/EX pipeline register directly downstream of the control unit. Each cycle it captures the decoded

---
 rtl/id_ex_pipe_pkg.sv | 20 ++
 rtl/id_ex_pipe_hazard_detect.sv | 26 ++
 rtl/id_ex_pipe.sv | 155 +++++++++++++++
 tb/tb_id_ex_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_pkg.sv
// rtl/id_ex_pipe_pkg.sv - shared widths and control-word bit order for ID/EX
package id_ex_pipe_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_ALUOP_W    = 8;
    localparam int DEF_CNT_W      = 16;

    // Control word is {regDst,branch,memRead,memToReg,memWrite,aluSrc,regWrite,aluOp};
    // offsets below are added to ALUOP_W to locate each single-bit flag.
    localparam int CTRL_BITS     = 7;
    localparam int CW_REG_WRITE  = 0;
    localparam int CW_ALU_SRC    = 1;
    localparam int CW_MEM_WRITE  = 2;
    localparam int CW_MEM_TO_REG = 3;
    localparam int CW_MEM_READ   = 4;
    localparam int CW_BRANCH     = 5;
    localparam int CW_REG_DST    = 6;

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// rtl/id_ex_pipe_hazard_detect.sv - combinational load-use hazard and IF/ID stall
module hazard_detect
    import id_ex_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  ex_hold,
    input  logic                  flush,
    output logic                  hz,
    output logic                  stall
);

    // $0 is hardwired zero, so a load targeting it never produces a dependency.
    assign hz = ex_valid & ex_mem_read & id_valid & (ex_rt != '0)
              & ((ex_rt == id_rs) | (ex_rt == id_rt));

    assign stall = ~reset & (ex_hold | (hz & ~flush));

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use bubble, hold and flush
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int ALUOP_W    = DEF_ALUOP_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  idValid,
    input  logic                  regDst,
    input  logic                  branch,
    input  logic                  memRead,
    input  logic                  memToReg,
    input  logic                  memWrite,
    input  logic                  aluSrc,
    input  logic                  regWrite,
    input  logic [ALUOP_W-1:0]    aluOp,
    input  logic [REG_ADDR_W-1:0] idRs,
    input  logic [REG_ADDR_W-1:0] idRt,
    input  logic [REG_ADDR_W-1:0] idRd,
    input  logic [DATA_W-1:0]     idRead1,
    input  logic [DATA_W-1:0]     idRead2,
    input  logic [DATA_W-1:0]     idImm,
    input  logic [DATA_W-1:0]     idPc,
    input  logic                  exHold,
    input  logic                  flush,
    output logic                  exValid,
    output logic                  exRegDst,
    output logic                  exBranch,
    output logic                  exMemRead,
    output logic                  exMemToReg,
    output logic                  exMemWrite,
    output logic                  exAluSrc,
    output logic                  exRegWrite,
    output logic [ALUOP_W-1:0]    exAluOp,
    output logic [REG_ADDR_W-1:0] exRs,
    output logic [REG_ADDR_W-1:0] exRt,
    output logic [REG_ADDR_W-1:0] exRd,
    output logic [DATA_W-1:0]     exRead1,
    output logic [DATA_W-1:0]     exRead2,
    output logic [DATA_W-1:0]     exImm,
    output logic [DATA_W-1:0]     exPc,
    output logic                  stallIfId,
    output logic [CNT_W-1:0]      bubbleCnt
);

    localparam int CW_W = ALUOP_W + CTRL_BITS;

    logic [CW_W-1:0]       ctrl_in, ctrl_d, ctrl_q;
    logic                  valid_d, valid_q;
    logic [REG_ADDR_W-1:0] rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
    logic [DATA_W-1:0]     read1_d, read1_q, read2_d, read2_q;
    logic [DATA_W-1:0]     imm_d, imm_q, pc_d, pc_q;
    logic [CNT_W-1:0]      cnt_d, cnt_q;
    logic                  hz;

    assign ctrl_in = {regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite, aluOp};

    hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
        .reset       (reset),
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q[ALUOP_W+CW_MEM_READ]),
        .ex_rt       (rt_q),
        .id_valid    (idValid),
        .id_rs       (idRs),
        .id_rt       (idRt),
        .ex_hold     (exHold),
        .flush       (flush),
        .hz          (hz),
        .stall       (stallIfId)
    );

    // Hold > flush > bubble > capture. Data fields are left alone on flush/bubble
    // since nothing downstream looks at them while exValid is low.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        read1_d = read1_q;
        read2_d = read2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (exHold) begin
            valid_d = valid_q;
        end else if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (hz) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            valid_d = idValid;
            ctrl_d  = idValid ? ctrl_in : '0;
            rs_d    = idRs;
            rt_d    = idRt;
            rd_d    = idRd;
            read1_d = idRead1;
            read2_d = idRead2;
            imm_d   = idImm;
            pc_d    = idPc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            read1_q <= '0;
            read2_q <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            read1_q <= read1_d;
            read2_q <= read2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign exValid    = valid_q;
    assign exRegDst   = ctrl_q[ALUOP_W+CW_REG_DST];
    assign exBranch   = ctrl_q[ALUOP_W+CW_BRANCH];
    assign exMemRead  = ctrl_q[ALUOP_W+CW_MEM_READ];
    assign exMemToReg = ctrl_q[ALUOP_W+CW_MEM_TO_REG];
    assign exMemWrite = ctrl_q[ALUOP_W+CW_MEM_WRITE];
    assign exAluSrc   = ctrl_q[ALUOP_W+CW_ALU_SRC];
    assign exRegWrite = ctrl_q[ALUOP_W+CW_REG_WRITE];
    assign exAluOp    = ctrl_q[ALUOP_W-1:0];
    assign exRs       = rs_q;
    assign exRt       = rt_q;
    assign exRd       = rd_q;
    assign exRead1    = read1_q;
    assign exRead2    = read2_q;
    assign exImm      = imm_q;
    assign exPc       = pc_q;
    assign bubbleCnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - self-checking bench for id_ex_pipe
module tb_id_ex_pipe;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 8;
    localparam int CW = 10;

    localparam logic [6:0] LW    = 7'b0011011;
    localparam logic [6:0] RTYPE = 7'b1000001;

    logic          clk = 1'b0;
    logic          reset;
    logic          idValid, regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite;
    logic [OW-1:0] aluOp;
    logic [AW-1:0] idRs, idRt, idRd;
    logic [DW-1:0] idRead1, idRead2, idImm, idPc;
    logic          exHold, flush;
    logic          exValid, exRegDst, exBranch, exMemRead, exMemToReg, exMemWrite, exAluSrc, exRegWrite;
    logic [OW-1:0] exAluOp;
    logic [AW-1:0] exRs, exRt, exRd;
    logic [DW-1:0] exRead1, exRead2, exImm, exPc;
    logic          stallIfId;
    logic [CW-1:0] bubbleCnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_pipe #(.DATA_W(DW), .REG_ADDR_W(AW), .ALUOP_W(OW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .idValid(idValid),
        .regDst(regDst), .branch(branch), .memRead(memRead), .memToReg(memToReg),
        .memWrite(memWrite), .aluSrc(aluSrc), .regWrite(regWrite), .aluOp(aluOp),
        .idRs(idRs), .idRt(idRt), .idRd(idRd),
        .idRead1(idRead1), .idRead2(idRead2), .idImm(idImm), .idPc(idPc),
        .exHold(exHold), .flush(flush), .exValid(exValid),
        .exRegDst(exRegDst), .exBranch(exBranch), .exMemRead(exMemRead), .exMemToReg(exMemToReg),
        .exMemWrite(exMemWrite), .exAluSrc(exAluSrc), .exRegWrite(exRegWrite), .exAluOp(exAluOp),
        .exRs(exRs), .exRt(exRt), .exRd(exRd),
        .exRead1(exRead1), .exRead2(exRead2), .exImm(exImm), .exPc(exPc),
        .stallIfId(stallIfId), .bubbleCnt(bubbleCnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what instruction should sit in EX and how many bubbles were inserted.
    typedef struct packed {
        logic          valid;
        logic [6:0]    cb;
        logic [OW-1:0] op;
        logic [AW-1:0] rs, rt, rd;
        logic [DW-1:0] r1, r2, imm, pc;
    } ex_t;

    ex_t           m;
    logic [CW-1:0] m_cnt;
    logic          m_bubble;
    logic          m_stall;

    always_comb begin
        m_bubble = m.valid && m.cb[4] && (m.rt != 0) && idValid && (idRs == m.rt || idRt == m.rt);
        m_stall  = !reset && (exHold || (m_bubble && !flush));
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m     <= '0;
            m_cnt <= '0;
        end else if (!exHold) begin
            if (flush || m_bubble) begin
                m.valid <= 1'b0;
                m.cb    <= '0;
                m.op    <= '0;
                if (!flush && m_cnt != {CW{1'b1}}) m_cnt <= m_cnt + 1;
            end else begin
                m.valid <= idValid;
                m.cb    <= idValid ? {regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite} : 7'b0;
                m.op    <= idValid ? aluOp : '0;
                m.rs    <= idRs;
                m.rt    <= idRt;
                m.rd    <= idRd;
                m.r1    <= idRead1;
                m.r2    <= idRead2;
                m.imm   <= idImm;
                m.pc    <= idPc;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("cmp_valid", 64'(exValid), 64'(m.valid));
            chk("cmp_ctrl", 64'({exRegDst, exBranch, exMemRead, exMemToReg, exMemWrite, exAluSrc, exRegWrite}),
                64'(m.cb));
            chk("cmp_aluop", 64'(exAluOp), 64'(m.op));
            chk("cmp_cnt", 64'(bubbleCnt), 64'(m_cnt));
            chk("cmp_stall", 64'(stallIfId), 64'(m_stall));
            if (m.valid) begin
                chk("cmp_regs", 64'({exRs, exRt, exRd}), 64'({m.rs, m.rt, m.rd}));
                chk("cmp_read1", 64'(exRead1), 64'(m.r1));
                chk("cmp_read2", 64'(exRead2), 64'(m.r2));
                chk("cmp_imm", 64'(exImm), 64'(m.imm));
                chk("cmp_pc", 64'(exPc), 64'(m.pc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        idValid = 1'b0;
        {regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite} = 7'b0;
        aluOp   = '0;
        idRs    = '0;
        idRt    = '0;
        idRd    = '0;
        idRead1 = $urandom;
        idRead2 = $urandom;
        idImm   = $urandom;
        idPc    = $urandom;
    endtask

    task automatic set_instr(input logic [6:0] cb, input logic [OW-1:0] op,
                             input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd);
        clear_id();
        idValid = 1'b1;
        {regDst, branch, memRead, memToReg, memWrite, aluSrc, regWrite} = cb;
        aluOp = op;
        idRs  = rs;
        idRt  = rt;
        idRd  = rd;
    endtask

    logic [CW-1:0] all_ones;

    initial begin
        all_ones = '1;
        clear_id();
        exHold = 1'b0;
        flush  = 1'b0;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_valid", 64'(exValid), 64'd0);
        chk("rst_cnt", 64'(bubbleCnt), 64'd0);

        // reset asserted mid-stream while a load sits in EX
        set_instr(LW, 8'h00, 5'd1, 5'd5, 5'd0);
        step();
        chk("t1_memread_before", 64'(exMemRead), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("t1_valid", 64'(exValid), 64'd0);
        chk("t1_memread", 64'(exMemRead), 64'd0);
        chk("t1_cnt", 64'(bubbleCnt), 64'd0);
        chk("t1_stall", 64'(stallIfId), 64'd0);
        #2 reset = 1'b0;
        step();
        chk("t1_after_release", 64'(exValid), 64'd1);

        // pass-through
        set_instr(7'b0000001, 8'h01, 5'd0, 5'd0, 5'd3);
        idRead1 = 32'h10;
        step();
        chk("t2_aluop", 64'(exAluOp), 64'h01);
        chk("t2_regwrite", 64'(exRegWrite), 64'd1);
        chk("t2_rd", 64'(exRd), 64'd3);
        chk("t2_read1", 64'(exRead1), 64'h10);
        chk("t2_valid", 64'(exValid), 64'd1);

        // load-use: one bubble, then consumer captured
        set_instr(LW, 8'h02, 5'd2, 5'd7, 5'd0);
        step();
        set_instr(RTYPE, 8'h20, 5'd7, 5'd3, 5'd8);
        #1 chk("t3_stall", 64'(stallIfId), 64'd1);
        step();
        chk("t3_bubble_valid", 64'(exValid), 64'd0);
        chk("t3_bubble_cnt", 64'(bubbleCnt), 64'd1);
        chk("t3_stall_after", 64'(stallIfId), 64'd0);
        step();
        chk("t3_consumer_valid", 64'(exValid), 64'd1);
        chk("t3_consumer_rs", 64'(exRs), 64'd7);

        // load-use together with flush: flush wins, no bubble counted
        set_instr(LW, 8'h02, 5'd2, 5'd7, 5'd0);
        step();
        set_instr(RTYPE, 8'h20, 5'd7, 5'd3, 5'd8);
        flush = 1'b1;
        #1 chk("t4_stall", 64'(stallIfId), 64'd0);
        step();
        chk("t4_valid", 64'(exValid), 64'd0);
        chk("t4_cnt", 64'(bubbleCnt), 64'd1);
        flush = 1'b0;

        // hold for three cycles with changing ID inputs
        set_instr(RTYPE, 8'h22, 5'd1, 5'd2, 5'd9);
        step();
        exHold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(RTYPE, 8'(8'h40 + i), 5'd1, 5'd2, 5'(10 + i));
            #1 chk("t5_stall", 64'(stallIfId), 64'd1);
            step();
            chk("t5_aluop_held", 64'(exAluOp), 64'h22);
            chk("t5_rd_held", 64'(exRd), 64'd9);
        end
        exHold = 1'b0;
        step();
        chk("t5_release_aluop", 64'(exAluOp), 64'h42);
        chk("t5_release_rd", 64'(exRd), 64'd12);

        // $0 never stalls
        set_instr(LW, 8'h00, 5'd0, 5'd0, 5'd0);
        step();
        set_instr(RTYPE, 8'h01, 5'd0, 5'd0, 5'd6);
        #1 chk("t6_r0_stall", 64'(stallIfId), 64'd0);
        step();
        chk("t6_r0_valid", 64'(exValid), 64'd1);
        chk("t6_r0_cnt", 64'(bubbleCnt), 64'd1);

        // saturation: more bubbles than the counter can hold
        for (int i = 0; i < (1 << CW) + 2; i++) begin
            set_instr(LW, 8'h00, 5'd0, 5'd4, 5'd0);
            step();
            set_instr(RTYPE, 8'h00, 5'd4, 5'd0, 5'd5);
            step();
        end
        chk("t6_saturated", 64'(bubbleCnt), 64'(all_ones));

        clear_id();
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
